ff_bank_arbiter: RTL and testbench

Shares one bank of `WIDTH` whitebox `FF` cells (set/reset/enable flip-flops with `NO_COMB` inputs) between `NREQ` requesters. The block arbitrates requests and drives the bank's `D`/`E`/`S`/`R` pins from registers, one cycle at a time, so that no combinational path runs from a requester into the FF pins. It then returns the bank's `Q` value to the winning requester. It sits between requester logic and the FF bank in the packed-cell test designs.

---
 rtl/ff_bank_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ff_bank_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_bank_arbiter.sv
// Arbitrates NREQ requesters onto one bank of FF cells, driving D/E/S/R from flops only.
// Define FF_BANK_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module ff_bank_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [2*NREQ-1:0]     req_op,
   input  logic [WIDTH*NREQ-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic [NREQ-1:0]       done,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  busy,
   output logic [WIDTH-1:0]      ff_D,
   output logic                  ff_E,
   output logic                  ff_S,
   output logic                  ff_R,
   input  logic [WIDTH-1:0]      bank_q
);

   localparam int          GW = $clog2(NREQ);
   localparam int unsigned NR = NREQ;

   typedef enum logic [1:0] {INIT, IDLE, ISSUE, SETTLE} state_t;
   typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_SET = 2'b01, OP_CLEAR = 2'b10, OP_READ = 2'b11} op_t;

   state_t           state, state_nxt;
   logic [GW-1:0]    gnt_q, gnt_q_n;
   logic             any_req;
   logic [GW-1:0]    gnt_idx;
   op_t              gnt_op;
   logic [WIDTH-1:0] gnt_data;

   logic [NREQ-1:0]  ready_n, done_n;
   logic [WIDTH-1:0] rd_n, ff_D_n;
   logic             busy_n, ff_E_n, ff_S_n, ff_R_n;

`ifdef FF_BANK_ARB_RR_EN
   logic [GW-1:0] ptr, ptr_n;

   function automatic int unsigned rr_slot(input int unsigned base, input int unsigned k);
      int unsigned s;
      s = base + k;
      return (s >= NR) ? s - NR : s;
   endfunction

   // Search order starts at ptr and wraps; the first valid requester in that order wins.
   always_comb begin
      any_req  = 1'b0;
      gnt_idx  = '0;
      gnt_op   = OP_READ;
      gnt_data = '0;
      for (int unsigned k = 0; k < NR; k++) begin
         for (int unsigned i = 0; i < NR; i++) begin
            if (!any_req && req_valid[i] && (i == rr_slot(int unsigned'(ptr), k))) begin
               any_req  = 1'b1;
               gnt_idx  = GW'(i);
               gnt_op   = op_t'(req_op[2*i +: 2]);
               gnt_data = req_data[WIDTH*i +: WIDTH];
            end
         end
      end
   end
`else
   always_comb begin
      any_req  = 1'b0;
      gnt_idx  = '0;
      gnt_op   = OP_READ;
      gnt_data = '0;
      for (int unsigned i = 0; i < NR; i++) begin
         if (!any_req && req_valid[i]) begin
            any_req  = 1'b1;
            gnt_idx  = GW'(i);
            gnt_op   = op_t'(req_op[2*i +: 2]);
            gnt_data = req_data[WIDTH*i +: WIDTH];
         end
      end
   end
`endif

   // State and every output are flops; the comb processes below only compute next values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= INIT;
         gnt_q     <= '0;
         req_ready <= '0;
         done      <= '0;
         rd_data   <= '0;
         busy      <= 1'b1;
         ff_D      <= '0;
         ff_E      <= 1'b0;
         ff_S      <= 1'b0;
         ff_R      <= 1'b1;
`ifdef FF_BANK_ARB_RR_EN
         ptr       <= '0;
`endif
      end else begin
         state     <= state_nxt;
         gnt_q     <= gnt_q_n;
         req_ready <= ready_n;
         done      <= done_n;
         rd_data   <= rd_n;
         busy      <= busy_n;
         ff_D      <= ff_D_n;
         ff_E      <= ff_E_n;
         ff_S      <= ff_S_n;
         ff_R      <= ff_R_n;
`ifdef FF_BANK_ARB_RR_EN
         ptr       <= ptr_n;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         INIT:    state_nxt = IDLE;
         IDLE:    if (any_req) state_nxt = ISSUE;
         ISSUE:   state_nxt = SETTLE;
         SETTLE:  state_nxt = IDLE;
         default: state_nxt = INIT;
      endcase
   end

   // Controls default low each cycle, so E/S/R pulse for exactly the ISSUE cycle.
   always_comb begin
      gnt_q_n = gnt_q;
      ready_n = '0;
      done_n  = '0;
      rd_n    = rd_data;
      ff_D_n  = ff_D;
      ff_E_n  = 1'b0;
      ff_S_n  = 1'b0;
      ff_R_n  = 1'b0;
      busy_n  = (state_nxt != IDLE);
`ifdef FF_BANK_ARB_RR_EN
      ptr_n   = ptr;
`endif
      case (state)
         IDLE: begin
            if (any_req) begin
               gnt_q_n = gnt_idx;
               ready_n = NREQ'(1) << gnt_idx;
`ifdef FF_BANK_ARB_RR_EN
               ptr_n   = GW'(rr_slot(int unsigned'(gnt_idx), 1));
`endif
               case (gnt_op)
                  OP_LOAD: begin
                     ff_D_n = gnt_data;
                     ff_E_n = 1'b1;
                  end
                  OP_SET:   ff_S_n = 1'b1;
                  OP_CLEAR: ff_R_n = 1'b1;
                  default:  ;
               endcase
            end
         end
         SETTLE: begin
            rd_n   = bank_q;
            done_n = NREQ'(1) << gnt_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// Self-checking bench for ff_bank_arbiter: directed scenarios plus randomized contention
// against a transaction-level model of arbitration order and bank contents.
module tb_ff_bank_arbiter;

   localparam int WIDTH = 8;
   localparam int NREQ  = 4;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [2*NREQ-1:0]     req_op;
   logic [WIDTH*NREQ-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       done;
   logic [WIDTH-1:0]      rd_data;
   logic                  busy;
   logic [WIDTH-1:0]      ff_D;
   logic                  ff_E, ff_S, ff_R;
   logic [WIDTH-1:0]      bank_q;
   logic [WIDTH-1:0]      bank;

   always #5 clk = ~clk;

   ff_bank_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
      .req_ready(req_ready), .done(done), .rd_data(rd_data), .busy(busy),
      .ff_D(ff_D), .ff_E(ff_E), .ff_S(ff_S), .ff_R(ff_R), .bank_q(bank_q)
   );

   // Behavioural FF bank driven by the DUT's pins.
   always @(posedge clk) begin
      if (ff_R)      bank <= '0;
      else if (ff_S) bank <= '1;
      else if (ff_E) bank <= ff_D;
   end
   assign bank_q = bank;

   int n_checks = 0;
   int n_fail   = 0;
   int ptr_m    = 0;
   logic [WIDTH-1:0] model_q  = '0;
   logic [WIDTH-1:0] exp_ffd  = '0;

   function automatic int model_grant(input logic [NREQ-1:0] v);
`ifdef FF_BANK_ARB_RR_EN
      for (int k = 0; k < NREQ; k++)
         if (v[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
`else
      for (int i = 0; i < NREQ; i++)
         if (v[i]) return i;
`endif
      return -1;
   endfunction

   function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] op, input logic [WIDTH-1:0] d,
                                                 input logic [WIDTH-1:0] q);
      case (op)
         2'b00:   return d;
         2'b01:   return '1;
         2'b10:   return '0;
         default: return q;
      endcase
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One granted transaction: req_valid must already present the winner; checks issue, settle, completion.
   task automatic run_grant(input logic [1:0] op, input logic [WIDTH-1:0] d, input int g,
                            input logic [NREQ-1:0] valid_after);
      logic [NREQ-1:0] oh;
      oh = NREQ'(1) << g;
      if (op == 2'b00) exp_ffd = d;
      tick;
      n_checks++;
      if (req_ready !== oh || done !== '0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL issue_strobe: ready=%b done=%b busy=%b, expected ready=%b done=0000 busy=1",
                  req_ready, done, busy, oh);
      end
      n_checks++;
      if (ff_E !== (op == 2'b00) || ff_S !== (op == 2'b01) || ff_R !== (op == 2'b10) || ff_D !== exp_ffd) begin
         n_fail++;
         $display("FAIL issue_pins: E=%b S=%b R=%b D=%h, expected E=%b S=%b R=%b D=%h",
                  ff_E, ff_S, ff_R, ff_D, op == 2'b00, op == 2'b01, op == 2'b10, exp_ffd);
      end
      ptr_m     = (g + 1) % NREQ;
      req_valid = valid_after;
      model_q   = apply_op(op, d, model_q);
      tick;
      n_checks++;
      if (req_ready !== '0 || done !== '0 || ff_E !== 1'b0 || ff_S !== 1'b0 || ff_R !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL settle: ready=%b done=%b E=%b S=%b R=%b busy=%b, expected all 0 except busy=1",
                  req_ready, done, ff_E, ff_S, ff_R, busy);
      end
      tick;
      n_checks++;
      if (done !== oh || rd_data !== model_q || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL complete: done=%b rd_data=%h busy=%b, expected done=%b rd_data=%h busy=0",
                  done, rd_data, busy, oh, model_q);
      end
   endtask

   task automatic single_op(input int i, input logic [1:0] op, input logic [WIDTH-1:0] d);
      req_valid             = '0;
      req_valid[i]          = 1'b1;
      req_op[2*i +: 2]      = op;
      req_data[WIDTH*i +: WIDTH] = d;
      run_grant(op, d, model_grant(req_valid), '0);
   endtask

   task automatic reset_dut;
      req_valid = '0;
      rst_n     = 1'b0;
      tick;
      tick;
      rst_n     = 1'b1;
      tick;
      ptr_m   = 0;
      model_q = '0;
      exp_ffd = '0;
   endtask

   task automatic test_reset;
      req_valid = '0;
      rst_n     = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick;
         n_checks++;
         if (ff_R !== 1'b1 || busy !== 1'b1 || ff_E !== 1'b0 || ff_S !== 1'b0 || req_ready !== '0 ||
             done !== '0 || rd_data !== '0 || ff_D !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: R=%b busy=%b E=%b S=%b ready=%b done=%b rd=%h D=%h, expected R=1 busy=1 rest 0",
                     ff_R, busy, ff_E, ff_S, req_ready, done, rd_data, ff_D);
         end
      end
      rst_n = 1'b1;
      #2;
      n_checks++;
      if (ff_R !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL init_cycle: R=%b busy=%b, expected R=1 busy=1", ff_R, busy);
      end
      tick;
      n_checks++;
      if (ff_R !== 1'b0 || busy !== 1'b0 || req_ready !== '0 || done !== '0) begin
         n_fail++;
         $display("FAIL idle_entry: R=%b busy=%b ready=%b done=%b, expected all 0", ff_R, busy, req_ready, done);
      end
      ptr_m   = 0;
      model_q = '0;
      exp_ffd = '0;
   endtask

   task automatic test_load;
      single_op(0, 2'b00, 8'hA5);
      single_op(1, 2'b11, 8'h00);
   endtask

   task automatic test_set_clear;
      single_op(2, 2'b01, 8'h3C);
      single_op(2, 2'b10, 8'hC3);
      single_op(3, 2'b00, 8'h5A);
      single_op(2, 2'b11, 8'h00);
   endtask

   task automatic test_contention;
      reset_dut;
      req_op    = '1;
      req_valid = '1;
      for (int k = 0; k < 5; k++)
         run_grant(2'b11, '0, model_grant(req_valid), '1);
      req_valid = '0;
      tick;
   endtask

   task automatic test_random;
      logic [NREQ-1:0] pend;
      int g;
      int iter;
      pend = '0;
      iter = 0;
      while ((iter < 30 || pend != '0) && iter < 80) begin
         if (iter < 30) begin
            for (int i = 0; i < NREQ; i++) begin
               if (!pend[i] && $urandom_range(1, 0) == 1) begin
                  pend[i]                    = 1'b1;
                  req_op[2*i +: 2]           = 2'($urandom_range(3, 0));
                  req_data[WIDTH*i +: WIDTH] = 8'($urandom);
               end
            end
            if (pend == '0) begin
               pend[0]        = 1'b1;
               req_op[1:0]    = 2'b00;
               req_data[7:0]  = 8'($urandom);
            end
         end
         req_valid = pend;
         g         = model_grant(pend);
         pend[g]   = 1'b0;
         run_grant(req_op[2*g +: 2], req_data[WIDTH*g +: WIDTH], g, pend);
         iter++;
      end
      req_valid = '0;
   endtask

   task automatic test_reset_midop;
      req_valid      = 4'b0010;
      req_op[3:2]    = 2'b00;
      req_data[15:8] = 8'h3C;
      tick;
      req_valid = '0;
      tick;
      rst_n = 1'b0;
      tick;
      n_checks++;
      if (done !== '0 || req_ready !== '0 || ff_R !== 1'b1 || busy !== 1'b1 || ff_E !== 1'b0) begin
         n_fail++;
         $display("FAIL midop_reset: done=%b ready=%b R=%b busy=%b E=%b, expected done=0 ready=0 R=1 busy=1 E=0",
                  done, req_ready, ff_R, busy, ff_E);
      end
      rst_n   = 1'b1;
      ptr_m   = 0;
      model_q = '0;
      exp_ffd = '0;
      tick;
      n_checks++;
      if (done !== '0 || ff_R !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midop_reinit: done=%b R=%b busy=%b, expected 0 0 0", done, ff_R, busy);
      end
      req_op    = '1;
      req_valid = 4'b1001;
      run_grant(2'b11, '0, model_grant(req_valid), 4'b1000);
      single_op(3, 2'b11, 8'h00);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_op    = '0;
      req_data  = '0;
      test_reset;
      test_load;
      test_set_clear;
      test_contention;
      test_random;
      test_reset_midop;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
